instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage of the multicycle RV32I core; sits directly downstream of the instruction ROM.
//  Owns the PC and drives the ROM word address.
//  Absorbs the ROM's one-cycle registered read latency.
//  Presents {instruction, pc} to decode via a valid/ready handshake.
//  Accepts branch/jump redirects and flags misaligned or out-of-range fetch targets.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  ADDR_W     14             ROM byte-address width; fetchable range is [0, 2**ADDR_W)
//  XLEN       32             PC / instruction width
// PORTS
//  clk            in   1       clock
//  rst_n          in   1       asynchronous, active-low reset
//  rom_addr       out  ADDR_W  byte address to ROM; equals pc[ADDR_W-1:0]
//  rom_data       in   XLEN    ROM output, valid one clk edge after rom_addr is presented
//  ir_valid       out  1       ir_data/ir_pc hold a fetched instruction
//  ir_ready       in   1       decode accepts the instruction this cycle
//  ir_data        out  XLEN    fetched instruction
//  ir_pc          out  XLEN    address of ir_data
//  redirect_valid in   1       load a new PC (branch/jump/trap)
//  redirect_pc    in   XLEN    new PC target
//  fetch_fault    out  1       sticky: fetch target misaligned or >= 2**ADDR_W
// BEHAVIOUR
//  Reset values: pc=RESET_PC, state=ADDR, ir_valid=0, ir_data=0, ir_pc=0, fetch_fault=0.
//  States:
//   ADDR : rom_addr=pc; next=DATA.
//   DATA : rom_data valid. At the clock edge: ir_data<=rom_data, ir_pc<=pc, pc<=pc+4; next=HOLD.
//   HOLD : ir_valid=1; ir_data/ir_pc stable. ir_valid & ir_ready -> next=ADDR, ir_valid=0; else stay.
//   FAULT: ir_valid=0, fetch_fault=1, rom_addr frozen; leaves only via a good redirect or reset.
//  Throughput: 3 cycles per instruction when ir_ready is high in HOLD. Back-pressure adds cycles in HOLD.
//  Redirect (any state, highest priority):
//   - Good target (redirect_pc[1:0]==0 and redirect_pc < 2**ADDR_W):
//     pc<=redirect_pc, ir_valid<=0, next=ADDR.
//   - In DATA the in-flight rom_data is discarded.
//   - Redirect with ir_ready in HOLD: the handshake counts as completed; pc still comes from redirect_pc.
//   - Bad target: pc<=redirect_pc, fetch_fault<=1, next=FAULT.
//  Sequential overflow: pc+4 reaching 2**ADDR_W -> fetch_fault<=1, next=FAULT.
//   The instruction just latched is still presented in HOLD first; FAULT is entered after it is accepted.
//  PC arithmetic: XLEN-bit modulo; pc[1:0] is always 0 outside FAULT.
//  Reset mid-operation: immediate return to reset values. The ROM output is also cleared, so no stale data.
//  Outputs are all registered except rom_addr, which is combinational from the pc register.
// STRUCTURE
//  fetch_pkg (shared):
//   - typedef enum logic [1:0] {FS_ADDR, FS_DATA, FS_HOLD, FS_FAULT} fetch_state_t
//   - INSTR_BYTES=4
//   - RV_NOP=32'h0000_0013
//  Sub-module fetch_pc_next: combinational next-PC select (redirect / +4 / hold) plus alignment and range check.
//  The FSM and output registers stay in instr_fetch_unit.
// TESTING (ROM behavioural model with registered output; word k = 32'hA000_0000+k)
//  1. Reset release, ir_ready=1:
//     rom_addr=0 in cycle 0, ir_valid=1 with ir_data=32'hA000_0000, ir_pc=0 in cycle 2;
//     next instruction ir_pc=4 in cycle 5.
//  2. ir_ready=0 for 6 cycles in HOLD:
//     ir_valid, ir_data, ir_pc stable throughout; rom_addr unchanged; pc advances only after ready.
//  3. redirect_pc=32'h40 asserted in DATA:
//     in-flight word discarded, ir_valid stays 0; next presented ir_pc=32'h40, ir_data=32'hA000_0010.
//  4. redirect_pc=32'h42:
//     fetch_fault=1 next cycle, ir_valid=0; then redirect_pc=32'h8 clears fetch_fault and fetches ir_pc=8.
//  5. redirect_pc=32'h3FFC (ADDR_W=14):
//     word at 32'h3FFC presented; after acceptance fetch_fault=1, no further ir_valid.
//  6. rst_n low for 1 cycle during HOLD:
//     all outputs to reset values asynchronously; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the RV32I fetch stage.
//                - fetch_state_t : fetch FSM state encoding
//                - INSTR_BYTES   : PC stride between sequential instructions
//                - RV_NOP        : canonical RV32I no-op (addi x0, x0, 0)
//                - is_word_aligned() : low-bit alignment test for fetch targets
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  typedef enum logic [1:0] {
    FS_ADDR  = 2'd0,
    FS_DATA  = 2'd1,
    FS_HOLD  = 2'd2,
    FS_FAULT = 2'd3
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] RV_NOP      = 32'h0000_0013;

  // A fetch target is word aligned when its two byte-offset bits are clear.
  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
//  Interface   : fetch_if
//  Description : Fetch -> decode instruction handshake.
//                master (fetch side)  : drives ir_valid, ir_data, ir_pc
//                slave  (decode side) : drives ir_ready
//                A transfer happens on a clock edge where ir_valid and
//                ir_ready are both high.
//  Signals     : ir_valid  1     instruction register holds a fetched word
//                ir_ready  1     decode accepts the word this cycle
//                ir_data   XLEN  fetched instruction
//                ir_pc     XLEN  byte address of ir_data
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_if #(
  parameter int XLEN = 32
) ();

  logic            ir_valid;
  logic            ir_ready;
  logic [XLEN-1:0] ir_data;
  logic [XLEN-1:0] ir_pc;

  modport master (
    output ir_valid,
    output ir_data,
    output ir_pc,
    input  ir_ready
  );

  modport slave (
    input  ir_valid,
    input  ir_data,
    input  ir_pc,
    output ir_ready
  );

endinterface : fetch_if
`default_nettype wire

// File: rtl/fetch_pc_next.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_next
//  Description : Combinational next-PC selection and fetch-target checks.
//                Priority: redirect > sequential advance (+4) > hold.
//                Also reports whether the redirect target and the current
//                PC are legal fetch addresses (word aligned and inside the
//                ROM byte range [0, 2**ADDR_W)).
//  Ports       : pc_i             in   XLEN  current PC register
//                advance_i        in   1     step to the next sequential word
//                redirect_valid_i in   1     branch/jump/trap redirect
//                redirect_pc_i    in   XLEN  redirect target
//                pc_next_o        out  XLEN  next value of the PC register
//                redirect_ok_o    out  1     redirect target is fetchable
//                pc_ok_o          out  1     current PC is fetchable
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_next
  import fetch_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 14
) (
  input  wire logic [XLEN-1:0] pc_i,
  input  wire logic            advance_i,
  input  wire logic            redirect_valid_i,
  input  wire logic [XLEN-1:0] redirect_pc_i,
  output logic      [XLEN-1:0] pc_next_o,
  output logic                 redirect_ok_o,
  output logic                 pc_ok_o
);

  logic [XLEN-1:0] pc_plus4;

  // Modulo-XLEN increment; a carry out of the ROM range is caught by the
  // range check on the resulting PC rather than here.
  assign pc_plus4 = pc_i + XLEN'(INSTR_BYTES);

  // Any set bit at or above ADDR_W puts the address outside the ROM.
  assign redirect_ok_o = is_word_aligned(redirect_pc_i[1:0])
                         && ((redirect_pc_i >> ADDR_W) == '0);
  assign pc_ok_o       = is_word_aligned(pc_i[1:0])
                         && ((pc_i >> ADDR_W) == '0);

  always_comb begin
    pc_next_o = pc_i;
    if (redirect_valid_i) begin
      pc_next_o = redirect_pc_i;
    end else if (advance_i) begin
      pc_next_o = pc_plus4;
    end
  end

endmodule : fetch_pc_next
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Fetch stage of the multicycle RV32I core. Owns the PC,
//                drives the instruction ROM word address, absorbs the ROM's
//                one-cycle registered read latency and presents
//                {instruction, pc} to decode over a valid/ready handshake.
//                Accepts redirects and traps into a sticky FAULT state on
//                misaligned or out-of-range fetch targets.
//                Sequence per instruction: ADDR -> DATA -> HOLD (3 cycles
//                with decode ready), back-pressure extends HOLD.
//  Ports       : clk              in   1       clock
//                rst_n            in   1       asynchronous active-low reset
//                rom_addr_o       out  ADDR_W  ROM byte address (= pc[ADDR_W-1:0])
//                rom_data_i       in   XLEN    ROM word, valid one edge after address
//                redirect_valid_i in   1       load a new PC
//                redirect_pc_i    in   XLEN    new PC target
//                fetch_fault_o    out  1       sticky bad-fetch-target flag
//                ir               fetch_if.master  instruction handshake to decode
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              ADDR_W   = 14,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  output logic      [ADDR_W-1:0] rom_addr_o,
  input  wire logic [XLEN-1:0]   rom_data_i,
  input  wire logic              redirect_valid_i,
  input  wire logic [XLEN-1:0]   redirect_pc_i,
  output logic                   fetch_fault_o,
  fetch_if.master                ir
);

  fetch_state_t    state_q,    state_d;
  logic [XLEN-1:0] pc_q,       pc_d;
  logic            ir_valid_q, ir_valid_d;
  logic [XLEN-1:0] ir_data_q,  ir_data_d;
  logic [XLEN-1:0] ir_pc_q,    ir_pc_d;
  logic            fault_q,    fault_d;

  logic            advance;
  logic            redirect_ok;
  logic            pc_ok;

  // --------------------------------------------------------------------------
  // Next-PC datapath
  // --------------------------------------------------------------------------
  fetch_pc_next #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W)
  ) u_pc_next (
    .pc_i             (pc_q),
    .advance_i        (advance),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .pc_next_o        (pc_d),
    .redirect_ok_o    (redirect_ok),
    .pc_ok_o          (pc_ok)
  );

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FS_ADDR;
      pc_q       <= RESET_PC;
      ir_valid_q <= 1'b0;
      ir_data_q  <= '0;
      ir_pc_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_valid_q <= ir_valid_d;
      ir_data_q  <= ir_data_d;
      ir_pc_q    <= ir_pc_d;
      fault_q    <= fault_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / output-register logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    ir_valid_d = ir_valid_q;
    ir_data_d  = ir_data_q;
    ir_pc_d    = ir_pc_q;
    fault_d    = fault_q;
    advance    = 1'b0;

    if (redirect_valid_i) begin
      // Redirect wins in every state. Whatever is in the instruction
      // register or in flight from the ROM is dropped; a simultaneous
      // HOLD handshake therefore simply completes.
      ir_valid_d = 1'b0;
      if (redirect_ok) begin
        state_d = FS_ADDR;
        fault_d = 1'b0;
      end else begin
        state_d = FS_FAULT;
        fault_d = 1'b1;
      end
    end else begin
      case (state_q)
        FS_ADDR: begin
          // Guards a RESET_PC that is itself not fetchable.
          if (!pc_ok) begin
            state_d = FS_FAULT;
            fault_d = 1'b1;
          end else begin
            state_d = FS_DATA;
          end
        end

        FS_DATA: begin
          ir_data_d  = rom_data_i;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          advance    = 1'b1;
          state_d    = FS_HOLD;
        end

        FS_HOLD: begin
          if (ir.ir_ready) begin
            ir_valid_d = 1'b0;
            // pc_q already holds the sequential successor here, so a
            // step past the end of the ROM is only reported once the
            // last legal instruction has been handed to decode.
            if (!pc_ok) begin
              state_d = FS_FAULT;
              fault_d = 1'b1;
            end else begin
              state_d = FS_ADDR;
            end
          end
        end

        FS_FAULT: begin
          ir_valid_d = 1'b0;
        end

        default: begin
          state_d = FS_ADDR;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // The PC only changes on redirects while in FAULT, so the ROM address
  // stays frozen there without extra gating.
  assign rom_addr_o    = pc_q[ADDR_W-1:0];
  assign fetch_fault_o = fault_q;

  assign ir.ir_valid   = ir_valid_q;
  assign ir.ir_data    = ir_data_q;
  assign ir.ir_pc      = ir_pc_q;

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit. A behavioural ROM
//                with registered output returns 32'hA000_0000 + word index.
//                Expected {instruction, pc} pairs are queued when the
//                stimulus makes them due; a negedge monitor pops one on
//                every accepted handshake. Timing/fault/stability checks
//                are made directly by the stimulus process.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 14;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] rom_addr;
  logic [XLEN-1:0]   rom_data;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              fetch_fault;

  fetch_if #(.XLEN(XLEN)) ir_bus ();

  instr_fetch_unit #(
    .XLEN     (XLEN),
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rom_addr_o       (rom_addr),
    .rom_data_i       (rom_data),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .fetch_fault_o    (fetch_fault),
    .ir               (ir_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: registered read, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rom_data <= '0;
    else        rom_data <= 32'hA000_0000 + 32'(rom_addr >> 2);
  end

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (ir_bus.ir_valid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check({name, "_valid_within_budget"}, 32'(ir_bus.ir_valid), 32'd1);
  endtask

  task automatic push(input logic [31:0] d, input logic [31:0] p);
    exp_t e;
    e.data = d;
    e.pc   = p;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: compare on every accepted handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ir_bus.ir_valid === 1'b1 && ir_bus.ir_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got ir_pc=%08h ir_data=%08h expected no transfer",
                 ir_bus.ir_pc, ir_bus.ir_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_ir_data", ir_bus.ir_data, mon_e.data);
        check("sb_ir_pc",   ir_bus.ir_pc,   mon_e.pc);
      end
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n           = 1'b0;
    ir_bus.ir_ready = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;

    // ---- Reset state ----
    step();
    step();
    check("rst_ir_valid", 32'(ir_bus.ir_valid), 32'd0);
    check("rst_ir_data",  ir_bus.ir_data,       32'd0);
    check("rst_ir_pc",    ir_bus.ir_pc,         32'd0);
    check("rst_fault",    32'(fetch_fault),     32'd0);
    check("rst_rom_addr", 32'(rom_addr),        32'd0);

    // ---- Test 1: reset release, decode always ready ----
    rst_n = 1'b1;                                   // cycle 0
    push(32'hA000_0000, 32'h0);
    push(32'hA000_0001, 32'h4);
    check("t1_c0_rom_addr", 32'(rom_addr), 32'd0);
    check("t1_c0_valid",    32'(ir_bus.ir_valid), 32'd0);
    step();                                         // cycle 1
    check("t1_c1_valid",    32'(ir_bus.ir_valid), 32'd0);
    step();                                         // cycle 2
    check("t1_c2_valid",    32'(ir_bus.ir_valid), 32'd1);
    check("t1_c2_ir_pc",    ir_bus.ir_pc,         32'h0);
    step();                                         // cycle 3
    check("t1_c3_valid",    32'(ir_bus.ir_valid), 32'd0);
    step();                                         // cycle 4
    step();                                         // cycle 5
    check("t1_c5_valid",    32'(ir_bus.ir_valid), 32'd1);
    check("t1_c5_ir_pc",    ir_bus.ir_pc,         32'h4);

    // ---- Test 2: back-pressure in HOLD ----
    step();                                         // ADDR pc=8
    ir_bus.ir_ready = 1'b0;
    push(32'hA000_0002, 32'h8);
    wait_valid("t2", 8);
    for (int i = 0; i < 6; i++) begin
      check("t2_hold_valid",    32'(ir_bus.ir_valid), 32'd1);
      check("t2_hold_ir_data",  ir_bus.ir_data,       32'hA000_0002);
      check("t2_hold_ir_pc",    ir_bus.ir_pc,         32'h8);
      check("t2_hold_rom_addr", 32'(rom_addr),        32'hC);
      step();
    end
    ir_bus.ir_ready = 1'b1;
    push(32'hA000_0003, 32'hC);
    step();                                         // accepted -> ADDR pc=C
    check("t2_post_valid",    32'(ir_bus.ir_valid), 32'd0);
    check("t2_post_rom_addr", 32'(rom_addr),        32'hC);
    wait_valid("t2b", 8);                           // HOLD pc=C

    // ---- Test 3: redirect in DATA discards in-flight word ----
    step();                                         // ADDR pc=10
    step();                                         // DATA pc=10
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    push(32'hA000_0010, 32'h40);
    step();                                         // ADDR pc=40
    redirect_valid = 1'b0;
    check("t3_valid_a",    32'(ir_bus.ir_valid), 32'd0);
    check("t3_rom_addr",   32'(rom_addr),        32'h40);
    step();                                         // DATA
    check("t3_valid_b",    32'(ir_bus.ir_valid), 32'd0);
    step();                                         // HOLD
    check("t3_valid_c",    32'(ir_bus.ir_valid), 32'd1);
    check("t3_ir_pc",      ir_bus.ir_pc,         32'h40);

    // ---- Test 4: misaligned redirect, then recovery ----
    step();                                         // ADDR pc=44
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    step();                                         // FAULT
    redirect_valid = 1'b0;
    check("t4_fault",      32'(fetch_fault),     32'd1);
    check("t4_valid",      32'(ir_bus.ir_valid), 32'd0);
    step();
    step();
    check("t4_fault_sticky", 32'(fetch_fault),     32'd1);
    check("t4_valid_sticky", 32'(ir_bus.ir_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8;
    push(32'hA000_0002, 32'h8);
    step();                                         // ADDR pc=8
    redirect_valid = 1'b0;
    check("t4_fault_cleared", 32'(fetch_fault), 32'd0);
    wait_valid("t4", 8);                            // HOLD pc=8

    // ---- Test 5: last ROM word, then sequential overflow ----
    step();                                         // ADDR pc=C
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3FFC;
    push(32'hA000_0FFF, 32'h3FFC);
    step();                                         // ADDR pc=3FFC
    redirect_valid = 1'b0;
    wait_valid("t5", 8);
    check("t5_ir_pc",  ir_bus.ir_pc,      32'h3FFC);
    step();                                         // accepted -> FAULT
    check("t5_fault",  32'(fetch_fault),  32'd1);
    for (int i = 0; i < 5; i++) begin
      check("t5_no_valid", 32'(ir_bus.ir_valid), 32'd0);
      step();
    end

    // ---- Test 6: asynchronous reset during HOLD ----
    ir_bus.ir_ready = 1'b0;
    redirect_valid  = 1'b1;
    redirect_pc     = 32'h20;
    push(32'hA000_0008, 32'h20);
    step();                                         // ADDR pc=20
    redirect_valid  = 1'b0;
    check("t6_fault_cleared", 32'(fetch_fault), 32'd0);
    wait_valid("t6", 8);
    check("t6_hold_ir_data", ir_bus.ir_data, 32'hA000_0008);
    #2;
    rst_n = 1'b0;
    exp_q.delete();                                 // held word never handed over
    #1;
    check("t6_async_valid",    32'(ir_bus.ir_valid), 32'd0);
    check("t6_async_ir_data",  ir_bus.ir_data,       32'd0);
    check("t6_async_ir_pc",    ir_bus.ir_pc,         32'd0);
    check("t6_async_rom_addr", 32'(rom_addr),        32'd0);
    check("t6_async_fault",    32'(fetch_fault),     32'd0);
    step();
    rst_n           = 1'b1;                         // cycle 0 again
    ir_bus.ir_ready = 1'b1;
    push(32'hA000_0000, 32'h0);
    check("t6_c0_rom_addr", 32'(rom_addr), 32'd0);
    step();
    check("t6_c1_valid", 32'(ir_bus.ir_valid), 32'd0);
    step();
    check("t6_c2_valid", 32'(ir_bus.ir_valid), 32'd1);
    check("t6_c2_ir_pc", ir_bus.ir_pc,         32'h0);
    step();
    step();

    check("sb_all_consumed", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_instr_fetch_unit
`default_nettype wire
